// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling,
// false-start rejection and stop-bit framing check.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       i_sys_clk,
  input  logic       i_rst,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Busy
);

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        fe_q, fe_d;
  logic        rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_Rx_Serial};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) state_d = rx_s ? IDLE : DATA;
        else cnt_d = cnt_q + 16'd1;
      end
      DATA: begin
        if (cnt_q == LAST) begin
          shift_d[idx_q] = rx_s;
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          if (rx_s) begin
            dv_d   = 1'b1;
            byte_d = shift_q;
          end else begin
            fe_d = 1'b1;
          end
          state_d = CLEANUP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      CLEANUP: begin
        // cnt 0 marks the first cycle here; a held-low line parks at cnt 1
        if (cnt_q == 16'd0) cnt_d = 16'd1;
        else if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Frame_Err = fe_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Busy      = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the receive-side counterpart of `uart_tx` and shares its baud parameter. Host commands enter the ILA through this block. It synchronises the asynchronous serial line, samples each bit at its midpoint, rejects glitch starts, and flags framing errors. Each good byte is presented for exactly one clock cycle.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clocks per bit, equal to i_sys_clk frequency / baud. Legal range is 4..65535.

Ports:
- `i_sys_clk`, input, 1 bit: system clock. The block has one clock domain.
- `i_rst`, input, 1 bit: reset, asynchronous and active-high.
- `i_Rx_Serial`, input, 1 bit: serial line. It is asynchronous to i_sys_clk and idles high.
- `o_Rx_DV`, output, 1 bit: one-cycle pulse when a byte with a valid stop bit completes.
- `o_Rx_Byte`, output, 8 bits: last good byte. It updates on the same edge that raises o_Rx_DV and holds its value otherwise.
- `o_Rx_Frame_Err`, output, 1 bit: one-cycle pulse when the stop bit samples low.
- `o_Rx_Busy`, output, 1 bit: high whenever the state is not IDLE.

## Operation
- **Synchroniser:** two flops on i_Rx_Serial, both reset to 1. The FSM uses only the second flop output, called `rx_s`.
- **Half-bit count:** H = (CLKS_PER_BIT-1)/2, using integer division.
- **Bit counter:** 16 bits, cleared on every state change.
- **Bit index:** 3 bits.
- **Shift register:** 8 bits.

State machine:
- **IDLE:** counter and index held at 0. rx_s = 0 moves to START.
- **START:** the counter increments until it equals H. On the next edge, rx_s is checked:
  - rx_s = 0: go to DATA with counter 0.
  - rx_s = 1: treat as a false start and return to IDLE. No output pulses.
- **DATA:** the counter increments until it equals CLKS_PER_BIT-1. On the next edge:
  - shift_reg[index] <= rx_s and the counter clears.
  - If index < 7, increment index. If index = 7, set index to 0 and go to STOP.
- **STOP:** the counter counts to CLKS_PER_BIT-1. On the next edge, rx_s is sampled:
  - rx_s = 1: o_Rx_DV <= 1 and o_Rx_Byte <= shift_reg.
  - rx_s = 0: o_Rx_Frame_Err <= 1. o_Rx_Byte is unchanged.
  - In both cases, go to CLEANUP.
- **CLEANUP:** o_Rx_DV and o_Rx_Frame_Err are cleared on the first edge here. The FSM stays in CLEANUP until rx_s = 1, then goes to IDLE.
  - This means a held-low line (break) produces exactly one frame error and no spurious start.
- **Illegal state encoding:** go to IDLE.
- o_Rx_DV and o_Rx_Frame_Err are never high in the same cycle.

## Timing
- **Reset values:** o_Rx_DV = 0, o_Rx_Frame_Err = 0, o_Rx_Busy = 0, o_Rx_Byte = 8'h00. State is IDLE and the synchroniser flops are 1.
- **Reset mid-frame:** reset takes effect immediately, without waiting for a clock edge. The partial byte is discarded and no pulse is produced. After release, the FSM waits for a new falling edge on rx_s.
- **Reference edge:** edge 0 is the first i_sys_clk posedge that samples i_Rx_Serial low.
  - rx_s goes low after edge 1.
  - The FSM enters START on edge 2.
  - The start midpoint check is at edge 3+H.
  - Data bit k is sampled at edge 3+H+(k+1)·CLKS_PER_BIT.
  - The stop bit is sampled at edge 3+H+9·CLKS_PER_BIT, which is also the edge where o_Rx_DV or o_Rx_Frame_Err rises. The pulse lasts exactly one cycle.
- **o_Rx_Busy:** rises on edge 2. After a good frame it falls two edges after the DV edge.
- **Back-to-back frames:** the next start bit may begin right after one stop-bit period with no idle gap, and it is received correctly. The CLEANUP overhead is 1 cycle, which is less than H.
- **Glitches:** a low pulse that ends before the midpoint check is rejected.

## Test plan
All tests use CLKS_PER_BIT = 8, so H = 3.
1. **Single byte:** drive 0x55 as 8N1 with 8-cycle bits -> o_Rx_DV pulses for 1 cycle at edge 78, o_Rx_Byte = 0x55, o_Rx_Frame_Err stays 0.
2. **Back-to-back bytes:** send 0xA5, 0x00, 0xFF with no idle gap -> three DV pulses exactly 80 cycles apart, with bytes in order 0xA5, 0x00, 0xFF.
3. **Glitch rejection:** drive i_Rx_Serial low for 2 cycles, then idle -> o_Rx_Busy pulses briefly, then no DV and no error. A following 0x3C is received correctly.
4. **Framing error:** send 0xC3 with the stop bit driven 0, then restore the line high -> a single o_Rx_Frame_Err pulse at edge 78, no DV, o_Rx_Byte keeps its previous value.
5. **Break:** hold the line low for 200 cycles -> exactly one frame error, no DV, and o_Rx_Busy stays high until the line returns high.
6. **Reset mid-frame:** assert i_rst during data bit 4 of 0x81 -> all outputs go to 0 immediately. After release, 0x7E is received correctly with no stale bits.
